// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to binary converter (reverse double dabble).
// Optional minus sign on the thousands digit: define BCD_SIGN_EN.
module bcd_to_bin_seq #(
   parameter int OUT_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       thou,
   input  logic [3:0]       hund,
   input  logic [3:0]       tens,
   input  logic [3:0]       ones,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             neg,
   output logic [OUT_W-1:0] bin_out
);

   localparam int SR_W  = OUT_W + 16;
   localparam int CNT_W = $clog2(OUT_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      FAIL
   } state_t;

   state_t           state;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  sr_nxt;
   logic [CNT_W-1:0] cnt;
   logic             sgn_q;

   logic             sign_in;
   logic             dig_bad;
   logic [3:0]       thou_ld;
   logic [OUT_W-1:0] mag;
   logic             neg_res;
   logic [OUT_W-1:0] res;

   always_comb begin
`ifdef BCD_SIGN_EN
      sign_in = (thou == 4'hA);
`else
      sign_in = 1'b0;
`endif
      dig_bad = (!sign_in && (thou > 4'd9)) ||
                (hund > 4'd9) ||
                (tens > 4'd9) ||
                (ones > 4'd9);
      thou_ld = sign_in ? 4'h0 : thou;
   end

   // One iteration: shift right, then pull each digit >= 8 back by 3
   always_comb begin
      sr_nxt = sr >> 1;
      for (int i = 0; i < 4; i++) begin
         if (sr_nxt[OUT_W+4*i +: 4] >= 4'd8)
            sr_nxt[OUT_W+4*i +: 4] = sr_nxt[OUT_W+4*i +: 4] - 4'd3;
      end
   end

   always_comb begin
      mag     = sr_nxt[OUT_W-1:0];
      neg_res = sgn_q && (mag != '0);
      res     = neg_res ? (~mag + 1'b1) : mag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         sgn_q   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         neg     <= 1'b0;
         bin_out <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (dig_bad) begin
                     state <= FAIL;
                  end else begin
                     sr    <= {thou_ld, hund, tens, ones, {OUT_W{1'b0}}};
                     cnt   <= '0;
                     sgn_q <= sign_in;
                     busy  <= 1'b1;
                     err   <= 1'b0;
                     state <= CONV;
                  end
               end
            end
            CONV: begin
               sr  <= sr_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(OUT_W - 1)) begin
                  bin_out <= res;
                  neg     <= neg_res;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            FAIL: begin
               err   <= 1'b1;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases plus random
// traffic against a transaction-level arithmetic model.
module tb_bcd_to_bin_seq;

   localparam int OUT_W = 14;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [3:0]       thou = '0;
   logic [3:0]       hund = '0;
   logic [3:0]       tens = '0;
   logic [3:0]       ones = '0;
   logic             busy;
   logic             done;
   logic             err;
   logic             neg;
   logic [OUT_W-1:0] bin_out;

   int checks = 0;
   int failures = 0;

   bcd_to_bin_seq #(.OUT_W(OUT_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .thou(thou),
      .hund(hund),
      .tens(tens),
      .ones(ones),
      .busy(busy),
      .done(done),
      .err(err),
      .neg(neg),
      .bin_out(bin_out)
   );

   always #5 clk = ~clk;

   // Reference model: edges left in a conversion, pending error, result
   int               rem = 0;
   bit               fpend = 0;
   logic             m_busy = 0;
   logic             m_done = 0;
   logic             m_err = 0;
   logic             m_neg = 0;
   logic [OUT_W-1:0] m_bin = '0;
   logic [OUT_W-1:0] p_val = '0;
   logic             p_neg = 0;

   always @(posedge clk or negedge rst_n) begin : model
      bit sg;
      bit bad;
      int mag;
      if (!rst_n) begin
         rem = 0; fpend = 0;
         m_busy = 0; m_done = 0; m_err = 0; m_neg = 0; m_bin = '0;
      end else begin
         m_done = 0;
         if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) begin
               m_done = 1; m_busy = 0; m_bin = p_val; m_neg = p_neg;
            end
         end else if (fpend) begin
            fpend = 0; m_done = 1; m_err = 1;
         end else if (start) begin
            sg = 0;
`ifdef BCD_SIGN_EN
            sg = (thou == 4'hA);
`endif
            bad = (!sg && thou > 9) || hund > 9 || tens > 9 || ones > 9;
            if (bad) begin
               fpend = 1;
            end else begin
               mag = 100 * hund + 10 * tens + ones + (sg ? 0 : 1000 * thou);
               p_neg = sg && (mag != 0);
               p_val = p_neg ? OUT_W'(-mag) : OUT_W'(mag);
               rem = OUT_W; m_busy = 1; m_err = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if ({busy, done, err, neg, bin_out} !==
          {m_busy, m_done, m_err, m_neg, m_bin}) begin
         failures++;
         $display("FAIL cycle t=%0t dut b/d/e/n=%b%b%b%b bin=%h model=%b%b%b%b bin=%h",
                  $time, busy, done, err, neg, bin_out,
                  m_busy, m_done, m_err, m_neg, m_bin);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; start is high across exactly one posedge
   task automatic go(input logic [3:0] t, h, te, o);
      thou = t; hund = h; tens = te; ones = o; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int cyc);
      cyc = 0;
      while (!done && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) chk("timeout", 32'(done), 32'd1);
   endtask

   int cyc;

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bin", 32'(bin_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      go(9, 9, 9, 9);
      chk("t1_busy", 32'(busy), 1);
      wait_done(40, cyc);
      chk("t1_lat", 32'(cyc), 14);
      chk("t1_bin", 32'(bin_out), 32'h270F);
      chk("t1_model", 32'(m_bin), 32'h270F);
      chk("t1_err", 32'(err), 0);

      go(0, 2, 5, 5);
      wait_done(40, cyc);
      chk("t2_bin", 32'(bin_out), 255);
      go(0, 0, 0, 0);
      wait_done(40, cyc);
      chk("t2_lat", 32'(cyc), 14);
      chk("t2_zero", 32'(bin_out), 0);

      go(0, 0, 4, 2);
      wait_done(40, cyc);
      go(1, 4'hC, 0, 0);
      wait_done(10, cyc);
      chk("t3_lat", 32'(cyc), 1);
      chk("t3_err", 32'(err), 1);
      chk("t3_bin", 32'(bin_out), 42);
      @(negedge clk);
      go(0, 0, 0, 7);
      chk("t3_clr", 32'(err), 0);
      wait_done(40, cyc);
      chk("t3_bin2", 32'(bin_out), 7);

      go(1, 2, 3, 4);
      repeat (3) @(negedge clk);
      go(9, 9, 9, 9);
      wait_done(40, cyc);
      chk("t4_bin", 32'(bin_out), 1234);
      chk("t4_model", 32'(m_bin), 1234);
      repeat (20) @(negedge clk);
      chk("t4_nodone", 32'(done), 0);
      chk("t4_hold", 32'(bin_out), 1234);

      go(5, 0, 0, 0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_bin", 32'(bin_out), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      go(5, 0, 0, 0);
      wait_done(40, cyc);
      chk("t5_bin2", 32'(bin_out), 5000);

      go(4'hA, 1, 2, 8);
      wait_done(40, cyc);
`ifdef BCD_SIGN_EN
      chk("t6_bin", 32'(bin_out), 32'h3F80);
      chk("t6_neg", 32'(neg), 1);
      go(4'hA, 0, 0, 0);
      wait_done(40, cyc);
      chk("t6_zero", 32'(bin_out), 0);
      chk("t6_zneg", 32'(neg), 0);
`else
      chk("t6_err", 32'(err), 1);
      chk("t6_neg", 32'(neg), 0);
`endif
      @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         thou = ($urandom % 8 == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
         hund = ($urandom % 16 == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
         tens = 4'($urandom % 10);
         ones = ($urandom % 16 == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
         start = ($urandom % 3 == 0);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
